// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer for the 5-stage MIPS core.
// Detects load-use hazards, taken-branch flushes and data-memory wait states,
// and sequences multi-cycle stalls with a small FSM. Outputs are combinational
// from the registered state/counter and the current inputs.
// Optional feature: define HAZARD_PERF_CNT_EN to add the 16-bit saturating
// stall_cycles counter (counts non-reset cycles with pc_write low).
module hazard_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        hazard_sel,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic        pipe_hold
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLstall  = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [2:0] LoadCntInit  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FlushCntInit = 3'(FLUSH_CYCLES - 1);
  localparam bit         LoadMulti    = (LOAD_STALL_CYCLES > 1);
  localparam bit         FlushMulti   = (FLUSH_CYCLES > 1);

  state_e     state;
  logic [2:0] cnt;
  logic       load_use;
  logic       mem_stall;

  // Hazard detection; a load to $zero never creates a dependency.
  always_comb begin
    load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mem_stall = mem_req && !mem_ready;
  end

  // State and down-counter; a memory stall freezes an in-progress bubble sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StRun;
      cnt   <= 3'd0;
    end else begin
      unique case (state)
        StRun: begin
          if (mem_stall) begin
            state <= StMemWait;
          end else if (branch_taken) begin
            if (FlushMulti) begin
              state <= StFlush;
              cnt   <= FlushCntInit;
            end
          end else if (load_use) begin
            if (LoadMulti) begin
              state <= StLstall;
              cnt   <= LoadCntInit;
            end
          end
        end
        StLstall, StFlush: begin
          if (!mem_stall) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state <= StRun;
            end
          end
        end
        StMemWait: begin
          if (mem_ready) begin
            state <= StRun;
          end
        end
        default: begin
          state <= StRun;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Output decode from state and live inputs; reset overrides everything.
  always_comb begin
    hazard_sel = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (rst) begin
      hazard_sel = 1'b1;
      ifid_flush = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          if (mem_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else if (branch_taken) begin
            hazard_sel = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use) begin
            hazard_sel = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end
        end
        StLstall: begin
          if (mem_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else begin
            hazard_sel = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end
        end
        StFlush: begin
          if (mem_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else begin
            hazard_sel = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        StMemWait: begin
          pipe_hold  = !mem_ready;
          pc_write   = mem_ready;
          ifid_write = mem_ready;
        end
        default: begin
          hazard_sel = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (LOAD_STALL_CYCLES=2, FLUSH_CYCLES=3).
// Expected output vector: {hazard_sel, pc_write, ifid_write, ifid_flush, pipe_hold}.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic       hazard_sel, pc_write, ifid_write, ifid_flush, pipe_hold;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(2),
    .FLUSH_CYCLES     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .hazard_sel  (hazard_sel),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .pipe_hold   (pipe_hold)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] ExpDef  = 5'b01100;
  localparam logic [4:0] ExpRst  = 5'b10010;
  localparam logic [4:0] ExpLstl = 5'b10000;
  localparam logic [4:0] ExpFlsh = 5'b11110;
  localparam logic [4:0] ExpHold = 5'b00001;

  typedef struct {
    logic [4:0] exp;
    string      nm;
  } item_t;

  item_t sb_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    exp_stall = 0;

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic mq, input logic my,
                      input logic [4:0] exp, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr;
    ex_rt = ert; branch_taken = br; mem_req = mq; mem_ready = my;
    it.exp = exp;
    it.nm  = nm;
    sb_q.push_back(it);
    if (!r && !exp[3]) exp_stall++;
  endtask

  task automatic idle(input logic [4:0] exp, input string nm);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, nm);
  endtask

  // Monitor: compare combinational outputs mid-cycle against the queued expectation.
  initial begin
    item_t      it;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {hazard_sel, pc_write, ifid_write, ifid_flush, pipe_hold};
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got %b expected %b (hsel,pcw,ifidw,flush,hold)",
                   it.nm, act, it.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ExpRst, "reset_0");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ExpRst, "reset_1");
    idle(ExpDef, "idle_after_reset");

    // Load-use on rs: 2 stall cycles then defaults.
    step(0, 8, 0, 0, 1, 8, 0, 0, 0, ExpLstl, "lu_rs_c1");
    idle(ExpLstl, "lu_rs_c2");
    idle(ExpDef, "lu_rs_done");

    // Load to $zero never stalls.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, ExpDef, "lu_zero");
    idle(ExpDef, "lu_zero_after");

    // rt match only counts when the ID instruction reads rt.
    step(0, 3, 9, 0, 1, 9, 0, 0, 0, ExpDef, "lu_rt_unused");
    step(0, 3, 9, 1, 1, 9, 0, 0, 0, ExpLstl, "lu_rt_c1");
    idle(ExpLstl, "lu_rt_c2");
    idle(ExpDef, "lu_rt_done");

    // Taken branch: 3 flush cycles; a second branch in cycle 2 is ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ExpFlsh, "br_c1");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ExpFlsh, "br_c2_rebranch");
    idle(ExpFlsh, "br_c3");
    idle(ExpDef, "br_done");

    // Memory wait: 3 hold cycles, then ready releases.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, ExpHold, "mem_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, ExpHold, "mem_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, ExpHold, "mem_c3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, ExpDef, "mem_ready");
    idle(ExpDef, "mem_done");

    // Branch beats load-use: flush only, no stall afterwards.
    step(0, 5, 0, 0, 1, 5, 1, 0, 0, ExpFlsh, "br_lu_c1");
    idle(ExpFlsh, "br_lu_c2");
    idle(ExpFlsh, "br_lu_c3");
    idle(ExpDef, "br_lu_done");

    // Memory stall freezes LSTALL.
    step(0, 7, 0, 0, 1, 7, 0, 0, 0, ExpLstl, "lsf_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, ExpHold, "lsf_frozen");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, ExpLstl, "lsf_resume");
    idle(ExpDef, "lsf_done");

    // Memory stall freezes FLUSH.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ExpFlsh, "flf_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, ExpHold, "flf_frozen");
    idle(ExpFlsh, "flf_c2");
    idle(ExpFlsh, "flf_c3");
    idle(ExpDef, "flf_done");

    // Memory stall has priority over branch in RUN.
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, ExpHold, "prio_mem_br");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, ExpDef, "prio_release");
    idle(ExpDef, "prio_done");

    // Reset in the second flush cycle aborts the flush.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ExpFlsh, "rf_c1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ExpRst, "rf_reset");
`ifdef HAZARD_PERF_CNT_EN
    exp_stall = 0;
`endif
    idle(ExpDef, "rf_after_1");
    idle(ExpDef, "rf_after_2");

    // Short drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stall);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
